// File: rtl/gen_cfg_sequencer_pkg.sv
// Shared definitions for the generator configuration sequencer: state
// encodings, the non-satellite config bundle and its reset defaults.
package gps_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_PHASE     = 3'd2,
      ST_RUN       = 3'd3,
      ST_PEND      = 3'd4,
      ST_STOP_WAIT = 3'd5
   } seq_state_e;

   localparam logic [7:0] DOPPLER_DEFAULT    = 8'hC0;
   localparam logic       MSG_PRESET_DEFAULT = 1'b1;

   // Fields that are updated on a code epoch (satellite ID is handled separately
   // because changing it forces a full restart).
   typedef struct packed {
      logic       use_msg_preset;
      logic       noise_off;
      logic       signal_off;
      logic [7:0] doppler;
      logic [7:0] snr;
   } gen_cfg_t;

   function automatic gen_cfg_t cfg_reset_value();
      gen_cfg_t v;
      v.use_msg_preset = MSG_PRESET_DEFAULT;
      v.noise_off      = 1'b0;
      v.signal_off     = 1'b0;
      v.doppler        = DOPPLER_DEFAULT;
      v.snr            = 8'h00;
      return v;
   endfunction

endpackage

// File: rtl/gen_cfg_sequencer_if.sv
// Config-in / generator-control-out bundle between the register bank side
// (master) and the configuration sequencer (slave).
interface gen_cfg_sequencer_if;

   logic        enable_in;
   logic [4:0]  n_sat_in;
   logic        use_msg_preset_in;
   logic        noise_off_in;
   logic        signal_off_in;
   logic        ca_phase_start_in;
   logic [15:0] ca_phase_in;
   logic [7:0]  doppler_in;
   logic [7:0]  snr_in;
   logic        epoch_in;

   logic        gen_enable_out;
   logic        gen_rst_out;
   logic        ca_phase_load_out;
   logic [15:0] ca_phase_val_out;
   logic [4:0]  n_sat_out;
   logic        use_msg_preset_out;
   logic        noise_off_out;
   logic        signal_off_out;
   logic [7:0]  doppler_out;
   logic [7:0]  snr_out;
   logic        cfg_pending_out;
   logic        epoch_timeout_out;

   modport master (
      output enable_in, n_sat_in, use_msg_preset_in, noise_off_in, signal_off_in,
             ca_phase_start_in, ca_phase_in, doppler_in, snr_in, epoch_in,
      input  gen_enable_out, gen_rst_out, ca_phase_load_out, ca_phase_val_out,
             n_sat_out, use_msg_preset_out, noise_off_out, signal_off_out,
             doppler_out, snr_out, cfg_pending_out, epoch_timeout_out
   );

   modport slave (
      input  enable_in, n_sat_in, use_msg_preset_in, noise_off_in, signal_off_in,
             ca_phase_start_in, ca_phase_in, doppler_in, snr_in, epoch_in,
      output gen_enable_out, gen_rst_out, ca_phase_load_out, ca_phase_val_out,
             n_sat_out, use_msg_preset_out, noise_off_out, signal_off_out,
             doppler_out, snr_out, cfg_pending_out, epoch_timeout_out
   );

endinterface

// File: rtl/gen_cfg_sequencer_epoch_timer.sv
// Epoch wait timer: counts cycles while waiting for a CA code rollover and
// substitutes a timeout when no epoch arrives within EPOCH_TIMEOUT cycles.
module cfg_epoch_timer #(
   parameter int EPOCH_TIMEOUT = 20000,
   parameter int TMR_W         = 15
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clear,
   input  logic run,
   input  logic epoch,
   output logic fire,
   output logic timeout
);

   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(EPOCH_TIMEOUT - 1);

   logic [TMR_W-1:0] tmr_r;
   logic             at_max_s;

   // Wait counter: cleared on entry to a waiting state, saturates at the limit.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tmr_r <= '0;
      end else if (clear) begin
         tmr_r <= '0;
      end else if (run && (tmr_r != TMR_MAX)) begin
         tmr_r <= tmr_r + TMR_W'(1);
      end else begin
         tmr_r <= tmr_r;
      end
   end

   assign at_max_s = (tmr_r == TMR_MAX);
   // A real epoch always takes precedence, so a coincident timeout is silent.
   assign fire     = run && (epoch || at_max_s);
   assign timeout  = run && at_max_s && !epoch;

endmodule

// File: rtl/gen_cfg_sequencer.sv
// Generator configuration sequencer: startup reset/phase-load sequence,
// restart on satellite change, and epoch-aligned config updates.
module gen_cfg_sequencer #(
   parameter int RST_CYCLES    = 4,
   parameter int EPOCH_TIMEOUT = 20000,
   parameter int TMR_W         = 15
) (
   input  logic               clk_in,
   input  logic               rst_in,
   gen_cfg_sequencer_if.slave bus
);

   import gps_cfg_pkg::*;

   localparam int               CNT_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(RST_CYCLES - 1);

   seq_state_e       state_r, next_state_s;
   logic [CNT_W-1:0] load_cnt_r;
   logic             start_prev_r, start_rise_s;
   logic             sat_diff_s, cfg_diff_s;
   gen_cfg_t         cfg_in_s, cfg_r, cfg_nxt_s;
   logic [4:0]       n_sat_r, n_sat_nxt_s;
   logic             tmr_clear_s, tmr_run_s, tmr_fire_s, tmr_timeout_s;
   logic             gen_enable_r, gen_enable_nxt_s;
   logic             gen_rst_r, gen_rst_nxt_s;
   logic             ca_load_r, ca_load_nxt_s;
   logic [15:0]      ca_val_r, ca_val_nxt_s;
   logic             pending_r, pending_nxt_s;
   logic             timeout_r, timeout_nxt_s;

   assign cfg_in_s = '{use_msg_preset: bus.use_msg_preset_in,
                       noise_off:      bus.noise_off_in,
                       signal_off:     bus.signal_off_in,
                       doppler:        bus.doppler_in,
                       snr:            bus.snr_in};

   assign sat_diff_s   = (bus.n_sat_in != n_sat_r);
   assign cfg_diff_s   = (cfg_in_s != cfg_r);
   assign start_rise_s = bus.ca_phase_start_in && !start_prev_r;

   assign tmr_run_s   = (state_r == ST_PEND) || (state_r == ST_STOP_WAIT);
   assign tmr_clear_s = ((next_state_s == ST_PEND)      && (state_r != ST_PEND)) ||
                        ((next_state_s == ST_STOP_WAIT) && (state_r != ST_STOP_WAIT));

   cfg_epoch_timer #(
      .EPOCH_TIMEOUT (EPOCH_TIMEOUT),
      .TMR_W         (TMR_W)
   ) u_timer (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .clear   (tmr_clear_s),
      .run     (tmr_run_s),
      .epoch   (bus.epoch_in),
      .fire    (tmr_fire_s),
      .timeout (tmr_timeout_s)
   );

   // State register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Reset-hold counter: counts cycles spent in LOAD, zero everywhere else.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         load_cnt_r <= '0;
      end else if ((state_r == ST_LOAD) && (load_cnt_r != LOAD_LAST)) begin
         load_cnt_r <= load_cnt_r + CNT_W'(1);
      end else begin
         load_cnt_r <= '0;
      end
   end

   // Edge-detect history for the CA phase restart request.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         start_prev_r <= 1'b0;
      end else begin
         start_prev_r <= bus.ca_phase_start_in;
      end
   end

   // Next-state decision; RUN/PEND branches are listed in priority order.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.enable_in) next_state_s = ST_LOAD;
            else               next_state_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (load_cnt_r == LOAD_LAST) next_state_s = ST_PHASE;
            else                         next_state_s = ST_LOAD;
         end
         ST_PHASE: next_state_s = ST_RUN;
         ST_RUN: begin
            if (!bus.enable_in)   next_state_s = ST_STOP_WAIT;
            else if (sat_diff_s)  next_state_s = ST_LOAD;
            else if (cfg_diff_s)  next_state_s = ST_PEND;
            else if (start_rise_s) next_state_s = ST_PHASE;
            else                  next_state_s = ST_RUN;
         end
         ST_PEND: begin
            if (!bus.enable_in)  next_state_s = ST_STOP_WAIT;
            else if (sat_diff_s) next_state_s = ST_LOAD;
            else if (tmr_fire_s) next_state_s = ST_RUN;
            else                 next_state_s = ST_PEND;
         end
         ST_STOP_WAIT: begin
            if (bus.enable_in)   next_state_s = ST_RUN;
            else if (tmr_fire_s) next_state_s = ST_IDLE;
            else                 next_state_s = ST_STOP_WAIT;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Next values of the registered generator controls and active config.
   always_comb begin
      gen_enable_nxt_s = gen_enable_r;
      gen_rst_nxt_s    = gen_rst_r;
      case (next_state_s)
         ST_IDLE, ST_LOAD: begin
            gen_enable_nxt_s = 1'b0;
            gen_rst_nxt_s    = 1'b1;
         end
         ST_PHASE: begin
            // Startup PHASE keeps the generator stopped; a RUN re-phase keeps it running.
            gen_enable_nxt_s = gen_enable_r;
            gen_rst_nxt_s    = 1'b0;
         end
         ST_RUN, ST_PEND, ST_STOP_WAIT: begin
            gen_enable_nxt_s = 1'b1;
            gen_rst_nxt_s    = 1'b0;
         end
         default: begin
            gen_enable_nxt_s = 1'b0;
            gen_rst_nxt_s    = 1'b1;
         end
      endcase

      ca_load_nxt_s = (next_state_s == ST_PHASE);
      if (next_state_s == ST_PHASE) begin
         ca_val_nxt_s = bus.ca_phase_in;
      end else begin
         ca_val_nxt_s = ca_val_r;
      end

      pending_nxt_s = (next_state_s == ST_PEND);
      timeout_nxt_s = tmr_timeout_s &&
                      (((state_r == ST_PEND) && (next_state_s == ST_RUN)) ||
                       ((state_r == ST_STOP_WAIT) && (next_state_s == ST_IDLE)));

      if ((state_r == ST_IDLE) || (state_r == ST_LOAD)) begin
         n_sat_nxt_s = bus.n_sat_in;
         cfg_nxt_s   = cfg_in_s;
      end else if ((state_r == ST_PEND) && (next_state_s == ST_RUN)) begin
         n_sat_nxt_s = n_sat_r;
         cfg_nxt_s   = cfg_in_s;
      end else begin
         n_sat_nxt_s = n_sat_r;
         cfg_nxt_s   = cfg_r;
      end
   end

   // Output registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         gen_enable_r <= 1'b0;
         gen_rst_r    <= 1'b1;
         ca_load_r    <= 1'b0;
         ca_val_r     <= 16'h0000;
         n_sat_r      <= 5'd0;
         cfg_r        <= cfg_reset_value();
         pending_r    <= 1'b0;
         timeout_r    <= 1'b0;
      end else begin
         gen_enable_r <= gen_enable_nxt_s;
         gen_rst_r    <= gen_rst_nxt_s;
         ca_load_r    <= ca_load_nxt_s;
         ca_val_r     <= ca_val_nxt_s;
         n_sat_r      <= n_sat_nxt_s;
         cfg_r        <= cfg_nxt_s;
         pending_r    <= pending_nxt_s;
         timeout_r    <= timeout_nxt_s;
      end
   end

   assign bus.gen_enable_out     = gen_enable_r;
   assign bus.gen_rst_out        = gen_rst_r;
   assign bus.ca_phase_load_out  = ca_load_r;
   assign bus.ca_phase_val_out   = ca_val_r;
   assign bus.n_sat_out          = n_sat_r;
   assign bus.use_msg_preset_out = cfg_r.use_msg_preset;
   assign bus.noise_off_out      = cfg_r.noise_off;
   assign bus.signal_off_out     = cfg_r.signal_off;
   assign bus.doppler_out        = cfg_r.doppler;
   assign bus.snr_out            = cfg_r.snr;
   assign bus.cfg_pending_out    = pending_r;
   assign bus.epoch_timeout_out  = timeout_r;

endmodule

// File: tb/tb_gen_cfg_sequencer.sv
// Directed + randomized bench for gen_cfg_sequencer with a timing model
// derived from the sequencing rules (cycle counts, expected active config).
module tb_gen_cfg_sequencer;

   localparam int RST_CYCLES    = 4;
   localparam int EPOCH_TIMEOUT = 20000;
   localparam int TMR_W         = 15;

   logic clk_in;
   logic rst_in;
   int   vectors     = 0;
   int   miscompares = 0;

   // Expected active configuration.
   logic [4:0] m_sat;
   logic       m_preset, m_noise, m_sig;
   logic [7:0] m_dop, m_snr;

   gen_cfg_sequencer_if bus_if ();

   gen_cfg_sequencer #(
      .RST_CYCLES    (RST_CYCLES),
      .EPOCH_TIMEOUT (EPOCH_TIMEOUT),
      .TMR_W         (TMR_W)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus_if)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic take_inputs(input bit with_sat);
      if (with_sat) m_sat = bus_if.n_sat_in;
      m_preset = bus_if.use_msg_preset_in;
      m_noise  = bus_if.noise_off_in;
      m_sig    = bus_if.signal_off_in;
      m_dop    = bus_if.doppler_in;
      m_snr    = bus_if.snr_in;
   endtask

   function automatic bit active_ok();
      return (bus_if.n_sat_out === m_sat) && (bus_if.use_msg_preset_out === m_preset) &&
             (bus_if.noise_off_out === m_noise) && (bus_if.signal_off_out === m_sig) &&
             (bus_if.doppler_out === m_dop) && (bus_if.snr_out === m_snr);
   endfunction

   task automatic check_active(input string tag);
      chk({tag, ".n_sat"},   32'(bus_if.n_sat_out),          32'(m_sat));
      chk({tag, ".preset"},  32'(bus_if.use_msg_preset_out), 32'(m_preset));
      chk({tag, ".noise"},   32'(bus_if.noise_off_out),      32'(m_noise));
      chk({tag, ".sig"},     32'(bus_if.signal_off_out),     32'(m_sig));
      chk({tag, ".doppler"}, 32'(bus_if.doppler_out),        32'(m_dop));
      chk({tag, ".snr"},     32'(bus_if.snr_out),            32'(m_snr));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".gen_rst"},  32'(bus_if.gen_rst_out),        32'd1);
      chk({tag, ".gen_en"},   32'(bus_if.gen_enable_out),     32'd0);
      chk({tag, ".load"},     32'(bus_if.ca_phase_load_out),  32'd0);
      chk({tag, ".val"},      32'(bus_if.ca_phase_val_out),   32'd0);
      chk({tag, ".n_sat"},    32'(bus_if.n_sat_out),          32'd0);
      chk({tag, ".preset"},   32'(bus_if.use_msg_preset_out), 32'd1);
      chk({tag, ".noise"},    32'(bus_if.noise_off_out),      32'd0);
      chk({tag, ".sig"},      32'(bus_if.signal_off_out),     32'd0);
      chk({tag, ".doppler"},  32'(bus_if.doppler_out),        32'hC0);
      chk({tag, ".snr"},      32'(bus_if.snr_out),            32'd0);
      chk({tag, ".pending"},  32'(bus_if.cfg_pending_out),    32'd0);
      chk({tag, ".timeout"},  32'(bus_if.epoch_timeout_out),  32'd0);
   endtask

   // Trigger (enable or satellite change) must already be on the inputs.
   task automatic start_sequence(input string tag, input logic [15:0] phase);
      int ok;
      ok = 0;
      for (int i = 0; i < RST_CYCLES; i++) begin
         tick();
         if ((bus_if.gen_rst_out === 1'b1) && (bus_if.gen_enable_out === 1'b0) &&
             (bus_if.ca_phase_load_out === 1'b0)) ok++;
      end
      chk({tag, ".rst_cycles"}, 32'(ok), 32'(RST_CYCLES));
      tick();
      chk({tag, ".load"},    32'(bus_if.ca_phase_load_out), 32'd1);
      chk({tag, ".val"},     32'(bus_if.ca_phase_val_out),  32'(phase));
      chk({tag, ".rst_off"}, 32'(bus_if.gen_rst_out),       32'd0);
      chk({tag, ".en_ph"},   32'(bus_if.gen_enable_out),    32'd0);
      tick();
      chk({tag, ".load_end"}, 32'(bus_if.ca_phase_load_out), 32'd0);
      chk({tag, ".en_run"},   32'(bus_if.gen_enable_out),    32'd1);
      take_inputs(1'b1);
      check_active(tag);
   endtask

   // A non-sat field change must already be on the inputs.
   task automatic apply_via_epoch(input string tag, input int n_wait, input bit mid_change);
      int hi;
      bit held;
      hi   = 0;
      held = 1'b1;
      for (int i = 0; i < n_wait; i++) begin
         tick();
         if (bus_if.cfg_pending_out === 1'b1) hi++;
         if (!active_ok() || (bus_if.epoch_timeout_out !== 1'b0) || (bus_if.gen_enable_out !== 1'b1))
            held = 1'b0;
         if (mid_change && (i == n_wait / 2)) bus_if.snr_in = 8'($urandom);
      end
      bus_if.epoch_in = 1'b1;
      tick();
      bus_if.epoch_in = 1'b0;
      take_inputs(1'b0);
      chk({tag, ".pend_cycles"}, 32'(hi), 32'(n_wait));
      chk({tag, ".held_old"},    32'(held), 32'd1);
      chk({tag, ".pend_off"},    32'(bus_if.cfg_pending_out),   32'd0);
      chk({tag, ".no_tmo"},      32'(bus_if.epoch_timeout_out), 32'd0);
      check_active(tag);
   endtask

   task automatic wait_timeout(input string tag);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && (n < EPOCH_TIMEOUT + 50)) begin
         tick();
         n++;
         if (bus_if.epoch_timeout_out === 1'b1) seen = 1'b1;
      end
      chk({tag, ".seen"},    32'(seen), 32'd1);
      chk({tag, ".latency"}, 32'(n),    32'(EPOCH_TIMEOUT + 1));
   endtask

   initial begin
      int n_tmo;
      logic [15:0] ph;
      rst_in                   = 1'b1;
      bus_if.enable_in         = 1'b0;
      bus_if.n_sat_in          = 5'd0;
      bus_if.use_msg_preset_in = 1'b0;
      bus_if.noise_off_in      = 1'b0;
      bus_if.signal_off_in     = 1'b0;
      bus_if.ca_phase_start_in = 1'b0;
      bus_if.ca_phase_in       = 16'h0000;
      bus_if.doppler_in        = 8'h00;
      bus_if.snr_in            = 8'h00;
      bus_if.epoch_in          = 1'b0;
      tick();
      tick();
      check_reset("reset");

      // IDLE tracks inputs; phase-start edges are ignored outside RUN.
      rst_in                   = 1'b0;
      bus_if.n_sat_in          = 5'd5;
      bus_if.ca_phase_in       = 16'h0123;
      bus_if.doppler_in        = 8'hC0;
      bus_if.snr_in            = 8'($urandom);
      bus_if.use_msg_preset_in = 1'($urandom);
      bus_if.noise_off_in      = 1'($urandom);
      bus_if.signal_off_in     = 1'($urandom);
      tick();
      tick();
      take_inputs(1'b1);
      check_active("idle");
      chk("idle.gen_rst", 32'(bus_if.gen_rst_out), 32'd1);
      bus_if.ca_phase_start_in = 1'b1;
      tick();
      chk("idle.start_ignored", 32'(bus_if.ca_phase_load_out), 32'd0);
      bus_if.ca_phase_start_in = 1'b0;
      tick();

      // Startup.
      bus_if.enable_in = 1'b1;
      start_sequence("startup", 16'h0123);

      // Doppler change applied on an epoch 100 cycles later.
      bus_if.doppler_in = 8'hC8;
      apply_via_epoch("dop_epoch", 100, 1'b0);

      // Randomized config changes with random epoch delays.
      for (int r = 0; r < 8; r++) begin
         bus_if.use_msg_preset_in = 1'($urandom);
         bus_if.noise_off_in      = 1'($urandom);
         bus_if.signal_off_in     = 1'($urandom);
         bus_if.doppler_in        = 8'($urandom);
         bus_if.snr_in            = 8'($urandom);
         if ((bus_if.doppler_in == m_dop) && (bus_if.snr_in == m_snr) &&
             (bus_if.use_msg_preset_in == m_preset) && (bus_if.noise_off_in == m_noise) &&
             (bus_if.signal_off_in == m_sig))
            bus_if.doppler_in = ~m_dop;
         apply_via_epoch("rand", int'($urandom_range(1, 60)), 1'($urandom));
      end

      // SNR change with no epoch: timeout substitutes.
      bus_if.snr_in = m_snr ^ 8'h5A;
      wait_timeout("pend_tmo");
      take_inputs(1'b0);
      chk("pend_tmo.pend_off", 32'(bus_if.cfg_pending_out), 32'd0);
      check_active("pend_tmo");
      tick();
      chk("pend_tmo.pulse_end", 32'(bus_if.epoch_timeout_out), 32'd0);

      // Epoch arriving exactly on the timeout cycle: epoch wins, no pulse.
      bus_if.doppler_in = m_dop ^ 8'h3C;
      n_tmo = 0;
      for (int i = 0; i < EPOCH_TIMEOUT; i++) begin
         tick();
         if (bus_if.epoch_timeout_out === 1'b1) n_tmo++;
      end
      bus_if.epoch_in = 1'b1;
      tick();
      bus_if.epoch_in = 1'b0;
      take_inputs(1'b0);
      chk("coinc.early_pulses", 32'(n_tmo), 32'd0);
      chk("coinc.no_tmo", 32'(bus_if.epoch_timeout_out), 32'd0);
      chk("coinc.pend_off", 32'(bus_if.cfg_pending_out), 32'd0);
      check_active("coinc");

      // Satellite change: full restart.
      ph = 16'($urandom);
      bus_if.ca_phase_in = ph;
      bus_if.n_sat_in    = 5'd12;
      start_sequence("sat_change", ph);

      // Phase restart request in RUN: single strobe, generator keeps running.
      ph = 16'($urandom);
      bus_if.ca_phase_in       = ph;
      bus_if.ca_phase_start_in = 1'b1;
      tick();
      chk("rephase.load",   32'(bus_if.ca_phase_load_out), 32'd1);
      chk("rephase.val",    32'(bus_if.ca_phase_val_out),  32'(ph));
      chk("rephase.en",     32'(bus_if.gen_enable_out),    32'd1);
      chk("rephase.rst",    32'(bus_if.gen_rst_out),       32'd0);
      n_tmo = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus_if.ca_phase_load_out === 1'b1) n_tmo++;
      end
      chk("rephase.single", 32'(n_tmo), 32'd0);
      bus_if.ca_phase_start_in = 1'b0;

      // Stop request cancelled before the epoch; still running afterwards.
      bus_if.enable_in = 1'b0;
      tick();
      chk("cancel.en_stop", 32'(bus_if.gen_enable_out), 32'd1);
      tick();
      tick();
      bus_if.enable_in = 1'b1;
      tick();
      chk("cancel.en_run", 32'(bus_if.gen_enable_out), 32'd1);
      bus_if.snr_in = m_snr + 8'd1;
      apply_via_epoch("cancel", 5, 1'b0);

      // Stop completed on an epoch.
      bus_if.enable_in = 1'b0;
      n_tmo = int'($urandom_range(2, 30));
      ph = 16'd0;
      for (int i = 0; i < n_tmo; i++) begin
         tick();
         if (bus_if.gen_enable_out === 1'b1) ph = ph + 16'd1;
      end
      chk("stop.en_held", 32'(ph), 32'(n_tmo));
      bus_if.epoch_in = 1'b1;
      tick();
      bus_if.epoch_in = 1'b0;
      chk("stop.en_off", 32'(bus_if.gen_enable_out),    32'd0);
      chk("stop.rst_on", 32'(bus_if.gen_rst_out),       32'd1);
      chk("stop.no_tmo", 32'(bus_if.epoch_timeout_out), 32'd0);
      bus_if.n_sat_in   = 5'($urandom);
      bus_if.doppler_in = 8'($urandom);
      tick();
      tick();
      take_inputs(1'b1);
      check_active("idle2");

      // Restart, then stop completed by timeout.
      ph = 16'($urandom);
      bus_if.ca_phase_in = ph;
      bus_if.enable_in   = 1'b1;
      start_sequence("restart", ph);
      bus_if.enable_in = 1'b0;
      wait_timeout("stop_tmo");
      chk("stop_tmo.en_off", 32'(bus_if.gen_enable_out), 32'd0);
      chk("stop_tmo.rst_on", 32'(bus_if.gen_rst_out),    32'd1);

      // Reset in the middle of LOAD, then a clean startup.
      bus_if.enable_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b1;
      tick();
      check_reset("mid_load_rst");
      rst_in = 1'b0;
      ph = 16'($urandom);
      bus_if.ca_phase_in = ph;
      start_sequence("after_rst", ph);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
